// File: rtl/aes_pkg.sv
// Shared types and constants for the AES lane dispatcher and its slots.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } slot_state_t;

endpackage

// File: rtl/aes_lane_slot.sv
// One dispatcher slot: tracks what its round-core lane is doing, holds the
// lane's finished block until it retires, and flags stray lane_ready pulses.
//
// state | meaning
// FREE  | lane idle, may take the next block
// RUN   | block sent to lane, waiting for lane_ready
// DONE  | result captured in holding, waiting to retire
import aes_pkg::*;

module aes_lane_slot #(
  parameter int DATA_W = AES_BLOCK_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispatch,
  input  logic              retire,
  input  logic              lane_ready,
  input  logic [DATA_W-1:0] lane_result,
  output slot_state_t       state,
  output logic [DATA_W-1:0] holding,
  output logic              err
);

  // Slot state machine, result capture and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FREE;
      holding <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        FREE: if (dispatch) state <= RUN;
        RUN: begin
          if (lane_ready) begin
            state   <= DONE;
            holding <= lane_result;
          end
        end
        DONE: if (retire) state <= FREE;
        default: state <= FREE;
      endcase
      // A lane may only report while it actually owns a block.
      if (lane_ready && (state != RUN)) err <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_lane_dispatcher.sv
// Spreads incoming AES blocks over NUM_LANES round cores and collects their
// results, either in dispatch order (ORDERED=1) or as lanes finish (ORDERED=0).
import aes_pkg::*;

module aes_lane_dispatcher #(
  parameter int NUM_LANES = 3,
  parameter int DATA_W    = AES_BLOCK_W,
  parameter int ORDERED   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          is_valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          encrypt_flag,
  output logic                          busy_out,
  output logic [NUM_LANES-1:0]          lane_enable,
  output logic [NUM_LANES-1:0]          lane_encrypt,
  output logic [NUM_LANES*DATA_W-1:0]   lane_data,
  input  logic [NUM_LANES-1:0]          lane_ready,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_data_out,
  output logic                          ready,
  output logic [DATA_W-1:0]             data_out,
  input  logic                          out_accept,
  output logic [$clog2(NUM_LANES+1)-1:0] lanes_used,
  output logic                          protocol_err
);

  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W = $clog2(NUM_LANES + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_LANES - 1);

  slot_state_t          slot_st [NUM_LANES];
  logic [DATA_W-1:0]    hold    [NUM_LANES];
  logic [NUM_LANES-1:0] slot_err;
  logic [NUM_LANES-1:0] disp_vec;
  logic [NUM_LANES-1:0] ret_vec;
  logic [PTR_W-1:0]     alloc_ptr, ret_ptr;
  logic [PTR_W-1:0]     disp_idx, ret_idx;
  logic                 disp_ok, ret_ok;
  logic                 accept, retire;

  // Pick the dispatch lane from registered slot state only.
  always_comb begin
    disp_idx = alloc_ptr;
    disp_ok  = 1'b0;
    if (ORDERED != 0) begin
      for (int i = 0; i < NUM_LANES; i++)
        if ((PTR_W'(i) == alloc_ptr) && (slot_st[i] == FREE)) disp_ok = 1'b1;
    end else begin
      // Descending scan so the lowest free lane is the one left standing.
      for (int i = NUM_LANES - 1; i >= 0; i--)
        if (slot_st[i] == FREE) begin
          disp_idx = PTR_W'(i);
          disp_ok  = 1'b1;
        end
    end
  end

  // Pick the retiring lane from registered slot state only.
  always_comb begin
    ret_idx = ret_ptr;
    ret_ok  = 1'b0;
    if (ORDERED != 0) begin
      for (int i = 0; i < NUM_LANES; i++)
        if ((PTR_W'(i) == ret_ptr) && (slot_st[i] == DONE)) ret_ok = 1'b1;
    end else begin
      for (int i = NUM_LANES - 1; i >= 0; i--)
        if (slot_st[i] == DONE) begin
          ret_idx = PTR_W'(i);
          ret_ok  = 1'b1;
        end
    end
  end

  assign busy_out = !disp_ok;
  assign ready    = ret_ok;
  assign accept   = is_valid && disp_ok;
  assign retire   = ret_ok && out_accept;

  // One-hot strobes to the slots, plus the result mux (zero while idle).
  always_comb begin
    disp_vec = '0;
    ret_vec  = '0;
    data_out = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      disp_vec[i] = accept && (disp_idx == PTR_W'(i));
      ret_vec[i]  = retire && (ret_idx == PTR_W'(i));
      if (ret_ok && (ret_idx == PTR_W'(i))) data_out = hold[i];
    end
  end

  // Occupancy count and combined error flag.
  always_comb begin
    lanes_used = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (slot_st[i] != FREE) lanes_used = lanes_used + CNT_W'(1);
  end

  assign protocol_err = |slot_err;

  // Round-robin pointers; they only move in ordered mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr <= '0;
      ret_ptr   <= '0;
    end else if (ORDERED != 0) begin
      if (accept) alloc_ptr <= (alloc_ptr == LAST) ? '0 : alloc_ptr + 1'b1;
      if (retire) ret_ptr   <= (ret_ptr == LAST) ? '0 : ret_ptr + 1'b1;
    end
  end

  // Registered lane launch: start pulse, mode and block for the chosen lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_enable  <= '0;
      lane_encrypt <= '0;
      lane_data    <= '0;
    end else begin
      lane_enable <= disp_vec;
      for (int i = 0; i < NUM_LANES; i++)
        if (disp_vec[i]) begin
          lane_data[i*DATA_W +: DATA_W] <= data_in;
          lane_encrypt[i]               <= encrypt_flag;
        end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_slot
    aes_lane_slot #(.DATA_W(DATA_W)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .dispatch    (disp_vec[g]),
      .retire      (ret_vec[g]),
      .lane_ready  (lane_ready[g]),
      .lane_result (lane_data_out[g*DATA_W +: DATA_W]),
      .state       (slot_st[g]),
      .holding     (hold[g]),
      .err         (slot_err[g])
    );
  end

endmodule

// File: tb/tb_aes_lane_dispatcher.sv
// Bench for aes_lane_dispatcher: one ordered and one unordered instance, the
// bench itself plays the round cores (result = block xor a mode mask).
module tb_aes_lane_dispatcher;

  localparam int N = 3;
  localparam int W = 128;
  localparam logic [W-1:0] M_ENC = 128'hA5A5_5A5A_C3C3_3C3C_0F1E_2D3C_4B5A_6978;
  localparam logic [W-1:0] M_DEC = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210;

  logic             clk, rst;
  logic             is_valid      [2];
  logic [W-1:0]     data_in       [2];
  logic             encrypt_flag  [2];
  logic             busy_out      [2];
  logic [N-1:0]     lane_enable   [2];
  logic [N-1:0]     lane_encrypt  [2];
  logic [N*W-1:0]   lane_data     [2];
  logic [N-1:0]     lane_ready    [2];
  logic [N*W-1:0]   lane_data_out [2];
  logic             ready         [2];
  logic [W-1:0]     data_out      [2];
  logic             out_accept    [2];
  logic [1:0]       lanes_used    [2];
  logic             protocol_err  [2];

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];

  function automatic logic [W-1:0] xf(input logic [W-1:0] d, input logic e);
    return d ^ (e ? M_ENC : M_DEC);
  endfunction

  function automatic logic [N*W-1:0] lane_fn(input logic [N*W-1:0] d, input logic [N-1:0] e);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = xf(d[i*W +: W], e[i]);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_lane_dispatcher #(.NUM_LANES(N), .DATA_W(W), .ORDERED((g == 0) ? 1 : 0)) dut (
      .clk           (clk),
      .rst           (rst),
      .is_valid      (is_valid[g]),
      .data_in       (data_in[g]),
      .encrypt_flag  (encrypt_flag[g]),
      .busy_out      (busy_out[g]),
      .lane_enable   (lane_enable[g]),
      .lane_encrypt  (lane_encrypt[g]),
      .lane_data     (lane_data[g]),
      .lane_ready    (lane_ready[g]),
      .lane_data_out (lane_data_out[g]),
      .ready         (ready[g]),
      .data_out      (data_out[g]),
      .out_accept    (out_accept[g]),
      .lanes_used    (lanes_used[g]),
      .protocol_err  (protocol_err[g])
    );
    assign lane_data_out[g] = lane_fn(lane_data[g], lane_encrypt[g]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int u, input logic [W-1:0] v);
    if (u == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one block for one cycle; returns just after the accepting edge.
  task automatic send(input int u, input logic [W-1:0] d, input logic e, input bit do_push);
    is_valid[u]     = 1'b1;
    data_in[u]      = d;
    encrypt_flag[u] = e;
    if (do_push) push(u, xf(d, e));
    step();
    is_valid[u] = 1'b0;
  endtask

  task automatic pulse(input int u, input logic [N-1:0] m);
    lane_ready[u] = m;
    step();
    lane_ready[u] = '0;
  endtask

  task automatic drain(input int u, input string tag);
    for (int k = 0; k < 40 && qsize(u) != 0; k++) step();
    check(tag, W'(qsize(u)), '0);
  endtask

  // Scoreboard: every retirement is compared against the next expected block.
  always @(negedge clk) begin
    if (!rst) begin
      if (ready[0] && out_accept[0]) begin
        if (q0.size() == 0) check("extra_o", data_out[0], '0);
        else check("ret_o", data_out[0], q0.pop_front());
      end
      if (ready[1] && out_accept[1]) begin
        if (q1.size() == 0) check("extra_u", data_out[1], '0);
        else check("ret_u", data_out[1], q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, c, d1, d2, e;
    a  = {$urandom, $urandom, $urandom, $urandom};
    b  = {$urandom, $urandom, $urandom, $urandom};
    c  = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    e  = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      is_valid[u] = 1'b0; data_in[u] = '0; encrypt_flag[u] = 1'b0;
      lane_ready[u] = '0; out_accept[u] = 1'b0;
    end
    repeat (3) step();
    rst = 1'b0;
    step();

    for (int u = 0; u < 2; u++) begin
      check("rst_busy",  W'(busy_out[u]), '0);
      check("rst_ready", W'(ready[u]), '0);
      check("rst_dout",  data_out[u], '0);
      check("rst_used",  W'(lanes_used[u]), '0);
      check("rst_err",   W'(protocol_err[u]), '0);
      check("rst_en",    W'(lane_enable[u]), '0);
      check("rst_ldata", lane_data[u][W-1:0], '0);
    end

    // Ordered: A,B,C back to back, fill all lanes.
    send(0, a, 1'b1, 1'b1);
    check("o_en_a",   W'(lane_enable[0]), W'(3'b001));
    check("o_data_a", lane_data[0][0*W +: W], a);
    check("o_enc_a",  W'(lane_encrypt[0][0]), W'(1'b1));
    send(0, b, 1'b0, 1'b1);
    check("o_en_b",   W'(lane_enable[0]), W'(3'b010));
    check("o_data_b", lane_data[0][1*W +: W], b);
    send(0, c, 1'b1, 1'b1);
    check("o_en_c",   W'(lane_enable[0]), W'(3'b100));
    check("o_busy_full", W'(busy_out[0]), W'(1'b1));
    check("o_used3",  W'(lanes_used[0]), W'(3));
    step();
    check("o_en_idle", W'(lane_enable[0]), '0);

    // Lane 2 finishes first: nothing may come out until lane 0 is done.
    pulse(0, 3'b100);
    check("o_wait_ready", W'(ready[0]), '0);
    check("o_wait_dout",  data_out[0], '0);
    pulse(0, 3'b001);
    check("o_ready_a", W'(ready[0]), W'(1'b1));
    // Downstream stalls for five cycles: result and backpressure hold.
    for (int k = 0; k < 5; k++) begin
      check("o_hold_dout", data_out[0], xf(a, 1'b1));
      check("o_hold_busy", W'(busy_out[0]), W'(1'b1));
      step();
    end
    out_accept[0] = 1'b1;
    step();
    check("o_after_a_ready", W'(ready[0]), '0);
    check("o_after_a_busy",  W'(busy_out[0]), '0);
    check("o_after_a_used",  W'(lanes_used[0]), W'(2));
    pulse(0, 3'b010);
    drain(0, "o_drain");
    check("o_used0", W'(lanes_used[0]), '0);

    // Unordered: same pattern, C must leave first, then A wins the tie.
    out_accept[1] = 1'b1;
    send(1, a, 1'b0, 1'b0);
    check("u_en_a", W'(lane_enable[1]), W'(3'b001));
    send(1, b, 1'b1, 1'b0);
    check("u_en_b", W'(lane_enable[1]), W'(3'b010));
    send(1, c, 1'b0, 1'b0);
    check("u_en_c", W'(lane_enable[1]), W'(3'b100));
    check("u_busy_full", W'(busy_out[1]), W'(1'b1));
    push(1, xf(c, 1'b0));
    push(1, xf(a, 1'b0));
    push(1, xf(b, 1'b1));
    pulse(1, 3'b100);
    check("u_first_c", data_out[1], xf(c, 1'b0));
    pulse(1, 3'b011);
    check("u_busy_freed", W'(busy_out[1]), '0);
    check("u_tie_a", data_out[1], xf(a, 1'b0));
    drain(1, "u_drain");
    check("u_used0", W'(lanes_used[1]), '0);

    // Stray lane_ready on an idle lane.
    pulse(0, 3'b010);
    check("err_set",   W'(protocol_err[0]), W'(1'b1));
    check("err_used",  W'(lanes_used[0]), '0);
    check("err_ready", W'(ready[0]), '0);
    repeat (3) step();
    check("err_sticky", W'(protocol_err[0]), W'(1'b1));
    check("err_other",  W'(protocol_err[1]), '0);

    // Reset with two blocks in flight discards them and rewinds the pointers.
    send(0, d1, 1'b1, 1'b0);
    send(0, d2, 1'b0, 1'b0);
    check("pre_rst_used", W'(lanes_used[0]), W'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", W'(ready[0]), '0);
    check("mid_rst_used",  W'(lanes_used[0]), '0);
    check("mid_rst_busy",  W'(busy_out[0]), '0);
    check("mid_rst_err",   W'(protocol_err[0]), '0);
    step();
    send(0, e, 1'b1, 1'b1);
    check("post_rst_lane0", W'(lane_enable[0]), W'(3'b001));
    // Lane answers in the launch cycle: result must be ready one edge later.
    pulse(0, 3'b001);
    check("latency_ready", W'(ready[0]), W'(1'b1));
    drain(0, "post_rst_drain");
    check("idle_dout", data_out[0], '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
